// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared FSM encoding and elaboration helpers for the round-robin multiplier arbiter
package mul_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mul_core.sv
// mul_core: registered unsigned multiplier, product resized to OUTPUT_WIDTH, loaded on enable
module mul_core #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [INPUT_WIDTH-1:0]  in0,
  input  logic [INPUT_WIDTH-1:0]  in1,
  output logic [OUTPUT_WIDTH-1:0] product
);
  logic [2*INPUT_WIDTH-1:0] full;
  assign full = {{INPUT_WIDTH{1'b0}}, in0} * {{INPUT_WIDTH{1'b0}}, in1};
  always_ff @(posedge clock or posedge reset)
    if (reset) product <= '0;
    else if (load) product <= OUTPUT_WIDTH'(full);
endmodule

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter: round-robin sharing of one registered multiplier, one op in flight, valid/ready both sides
module mul_rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ID_WIDTH     = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in0,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in1,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [OUTPUT_WIDTH-1:0]        rsp_data,
  output logic                           busy
);
  if (ID_WIDTH < clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 16) begin : g_param_check
    $error("mul_rr_arbiter: NUM_REQ must be 2..16 and ID_WIDTH >= clog2(NUM_REQ)");
  end
  state_t state, state_next;
  logic [ID_WIDTH-1:0] last_grant, pick, cand;
  logic [INPUT_WIDTH-1:0] op0, op1;
  logic any, accept;
  assign any = |req_valid;
  assign accept = state == IDLE && any;
  // Scan from farthest to nearest so the requester closest after last_grant wins.
  always_comb begin
    pick = last_grant;
    cand = last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      pick = req_valid[cand] ? cand : pick;
    end
  end
  always_comb begin
    state_next = accept ? ISSUE : state == ISSUE ? DONE : (state == DONE && rsp_ready) ? IDLE : state;
    req_ready = (accept && !reset) ? NUM_REQ'(1) << pick : '0;
    rsp_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      rsp_id <= '0;
      op0 <= '0;
      op1 <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant <= pick;
        rsp_id <= pick;
        op0 <= req_in0[pick*INPUT_WIDTH +: INPUT_WIDTH];
        op1 <= req_in1[pick*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end
  mul_core #(.INPUT_WIDTH(INPUT_WIDTH), .OUTPUT_WIDTH(OUTPUT_WIDTH)) u_core (
    .clock(clock),
    .reset(reset),
    .load(state == ISSUE),
    .in0(op0),
    .in1(op1),
    .product(rsp_data)
  );
endmodule

// File: tb/tb_mul_rr_arbiter.sv
// tb_mul_rr_arbiter: scoreboard bench for the round-robin multiplier arbiter (16-bit and 8-bit result builds)
module tb_mul_rr_arbiter;
  typedef struct { int id; logic [15:0] d16; logic [7:0] d8; } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_in0 = '0, req_in1 = '0;
  logic rsp_ready = 1'b0;
  logic [3:0] req_ready, req_ready8;
  logic rsp_valid, rsp_valid8, busy, busy8;
  logic [1:0] rsp_id, rsp_id8;
  logic [15:0] rsp_data;
  logic [7:0] rsp_data8;
  int checks = 0, errors = 0, model_last = 3;
  exp_t sb[$];
  always #5 clock = ~clock;

  mul_rr_arbiter #(.NUM_REQ(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .ID_WIDTH(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_in0(req_in0), .req_in1(req_in1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy));
  mul_rr_arbiter #(.NUM_REQ(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(8), .ID_WIDTH(2)) dut8 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready8),
    .req_in0(req_in0), .req_in1(req_in1), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id8), .rsp_data(rsp_data8), .busy(busy8));

  function automatic int pick_of(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clock) begin
    int g;
    exp_t e;
    logic [3:0] oh;
    if (reset) begin
      sb.delete();
      model_last = 3;
    end else begin
      if (|(req_valid & req_ready)) begin
        g = pick_of(req_valid, model_last);
        oh = 4'b0001 << g;
        checks++;
        if (req_ready !== oh || req_ready8 !== oh) begin
          errors++;
          $display("FAIL sb_grant: req_ready=%b/%b expected %b", req_ready, req_ready8, oh);
        end
        e.id = g;
        e.d16 = req_in0[g*8 +: 8] * req_in1[g*8 +: 8];
        e.d8 = e.d16[7:0];
        sb.push_back(e);
        model_last = g;
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_rsp: unexpected response id=%0d data=%h", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== 2'(e.id) || rsp_data !== e.d16 || rsp_data8 !== e.d8 || rsp_id8 !== 2'(e.id)) begin
            errors++;
            $display("FAIL sb_rsp: id=%0d data=%h/%h expected id=%0d data=%h/%h",
                     rsp_id, rsp_data, rsp_data8, e.id, e.d16, e.d8);
          end
        end
      end
    end
  end

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 20 && g == 4'b0; i++) begin
      @(negedge clock);
      g = req_ready;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b0101;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b id=%0d data=%h busy=%b expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_data, busy);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b ready=%b expected 0/0000", busy, req_ready);
    end
  endtask

  task automatic test_single();
    @(posedge clock); #1;
    req_in0[7:0] = 8'd12;
    req_in1[7:0] = 8'd11;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: req_ready=%b expected 0001", req_ready);
    end
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: ready=%b valid=%b busy=%b expected 0000/0/1", req_ready, rsp_valid, busy);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'd132) begin
      errors++;
      $display("FAIL single_rsp: valid=%b id=%0d data=%0d expected 1/0/132", rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: valid=%b busy=%b expected 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int expg = 1, n = 0, last_cyc = -1;
    @(posedge clock); #1;
    req_in0 = $urandom();
    req_in1 = $urandom();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      @(negedge clock);
      if (req_ready != 4'b0) begin
        checks++;
        if (req_ready !== (4'b0001 << expg)) begin
          errors++;
          $display("FAIL rr_order: req_ready=%b expected %b", req_ready, 4'b0001 << expg);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++;
            $display("FAIL rr_interval: %0d cycles expected 3", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        expg = (expg + 1) % 4;
        n++;
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL rr_timeout: %0d grants expected 8", n);
    end
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    @(posedge clock); #1;
    req_valid = 4'b1000;
    wait_grant(g);
    checks++;
    if (g !== 4'b1000) begin errors++; $display("FAIL wrap_setup: grant=%b expected 1000", g); end
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();
    @(posedge clock); #1;
    req_valid = 4'b0110;
    wait_grant(g);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL wrap_first: grant=%b expected 0010", g); end
    @(posedge clock); #1;
    req_valid = 4'b0100;
    wait_grant(g);
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL wrap_second: grant=%b expected 0100", g); end
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [3:0] g;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    req_in0[15:0] = {8'd3, 8'hFF};
    req_in1[15:0] = {8'd5, 8'hFF};
    req_valid = 4'b0011;
    wait_grant(g);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL bp_grant: grant=%b expected 0001", g); end
    @(posedge clock); #1;
    req_valid = 4'b0010;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hFE01) begin
      errors++;
      $display("FAIL width16: valid=%b data=%h expected 1/fe01", rsp_valid, rsp_data);
    end
    checks++;
    if (rsp_valid8 !== 1'b1 || rsp_data8 !== 8'h01) begin
      errors++;
      $display("FAIL width8: valid=%b data=%h expected 1/01", rsp_valid8, rsp_data8);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'hFE01 || req_ready !== 4'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: valid=%b id=%0d data=%h ready=%b busy=%b expected 1/0/fe01/0000/1",
                 rsp_valid, rsp_id, rsp_data, req_ready, busy);
      end
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_grant: ready=%b valid=%b expected 0010/0", req_ready, rsp_valid);
    end
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    req_in0[23:16] = 8'd7;
    req_in1[23:16] = 8'd9;
    req_valid = 4'b0100;
    wait_grant(g);
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL mid_grant: grant=%b expected 0100", g); end
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'd63) begin
      errors++;
      $display("FAIL mid_done: valid=%b data=%0d expected 1/63", rsp_valid, rsp_data);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 16'd0 ||
          rsp_data8 !== 8'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset: ready=%b valid=%b id=%0d data=%h busy=%b expected all 0",
                 req_ready, rsp_valid, rsp_id, rsp_data, busy);
      end
      @(posedge clock); #1;
    end
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_rsp: valid=%b busy=%b expected 0/0", rsp_valid, busy);
      end
    end
    @(posedge clock); #1;
    req_valid = 4'hF;
    wait_grant(g);
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL reset_pointer: grant=%b expected 0001", g); end
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int expg = 2, n = 0;
    @(posedge clock); #1;
    req_in0 = $urandom();
    req_in1 = $urandom();
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      @(negedge clock);
      if (req_ready != 4'b0) begin
        checks++;
        if (req_ready !== (4'b0001 << expg)) begin
          errors++;
          $display("FAIL b2b_order: req_ready=%b expected %b", req_ready, 4'b0001 << expg);
        end
        expg = 2 - expg;
        n++;
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL b2b_timeout: %0d grants expected 6", n); end
    @(posedge clock); #1;
    req_valid = '0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
